// File: rtl/mbt_lane_engine.sv
// Frame-scanning Mandelbrot engine: LANES fixed-point escape iterators share one FSM
// and emit one packed word of per-pixel iteration counts per horizontal pixel group.

module mbt_lane #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 11
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic             active_in,
    input  logic [WIDTH-1:0] c_re_in,
    input  logic [WIDTH-1:0] c_im_in,
    input  logic [7:0]       max_iter,
    output logic             active,
    output logic             fin,
    output logic [7:0]       count
);
    localparam int W2 = 2 * WIDTH;
    localparam logic signed [W2-1:0] ESC_LIM = W2'(4 << FRAC);

    logic signed [WIDTH-1:0] zr_q, zr_d, zi_q, zi_d, c_re_q, c_re_d, c_im_q, c_im_d;
    logic [7:0]              count_q, count_d;
    logic                    frozen_q, frozen_d, active_q, active_d;
    logic signed [W2-1:0]    zr_x, zi_x, zr2, zi2, zri, mag;
    logic                    esc, sat;

    always_comb begin
        zr_x = W2'(zr_q);
        zi_x = W2'(zi_q);
        zr2  = (zr_x * zr_x) >>> FRAC;
        zi2  = (zi_x * zi_x) >>> FRAC;
        zri  = (zr_x * zi_x) >>> FRAC;
        // Escape test on the full-width sum so large z never wraps back inside
        mag  = zr2 + zi2;
        esc  = mag > ESC_LIM;
        sat  = count_q == max_iter;
        fin  = frozen_q | esc | sat;

        zr_d     = zr_q;
        zi_d     = zi_q;
        c_re_d   = c_re_q;
        c_im_d   = c_im_q;
        count_d  = count_q;
        frozen_d = frozen_q;
        active_d = active_q;
        if (load) begin
            zr_d     = '0;
            zi_d     = '0;
            c_re_d   = c_re_in;
            c_im_d   = c_im_in;
            count_d  = '0;
            frozen_d = !active_in;
            active_d = active_in;
        end else if (run && !frozen_q) begin
            if (esc || sat) begin
                frozen_d = 1'b1;
            end else begin
                zr_d    = WIDTH'(zr2 - zi2 + W2'(c_re_q));
                zi_d    = WIDTH'((zri <<< 1) + W2'(c_im_q));
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            zr_q     <= '0;
            zi_q     <= '0;
            c_re_q   <= '0;
            c_im_q   <= '0;
            count_q  <= '0;
            frozen_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            zr_q     <= zr_d;
            zi_q     <= zi_d;
            c_re_q   <= c_re_d;
            c_im_q   <= c_im_d;
            count_q  <= count_d;
            frozen_q <= frozen_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;
    assign count  = count_q;
endmodule

module mbt_lane_engine #(
    parameter int LANES  = 4,
    parameter int WIDTH  = 16,
    parameter int FRAC   = 11,
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17
) (
    input  logic                 clk_fast,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     x_min,
    input  logic [WIDTH-1:0]     y_max,
    input  logic [WIDTH-1:0]     step,
    input  logic [7:0]           max_iter,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [8*LANES-1:0]   wr_data,
    output logic [LANES-1:0]     wr_be,
    input  logic                 wr_ready,
    output logic                 busy,
    output logic                 done
);
    localparam int GPR  = (H_RES + LANES - 1) / LANES;
    localparam int GX_W = $clog2(GPR + 1);
    localparam int Y_W  = $clog2(V_RES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ITER, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [GX_W-1:0]     gx_q, gx_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]    x_min_q, x_min_d, y_max_q, y_max_d, step_q, step_d;
    logic [7:0]          max_iter_q, max_iter_d;
    logic                wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
    logic [8*LANES-1:0]  wr_data_q, wr_data_d;
    logic [LANES-1:0]    wr_be_q, wr_be_d;

    logic [LANES-1:0]             lane_act_in, lane_active, lane_fin;
    logic [LANES-1:0][WIDTH-1:0]  c_re;
    logic [LANES-1:0][7:0]        lane_cnt;
    logic [WIDTH-1:0]             c_im;
    logic                         lane_load, lane_run, last_grp, row_end;

    assign lane_load = state_q == LOAD;
    assign lane_run  = state_q == ITER;
    assign c_im      = y_max_q - WIDTH'(y_q) * step_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [31:0] px;
        // Pixels past the right edge in the final group of a row stay masked
        assign px             = 32'(gx_q) * 32'(LANES) + 32'(k);
        assign lane_act_in[k] = px < 32'(H_RES);
        assign c_re[k]        = x_min_q + WIDTH'(px) * step_q;

        mbt_lane #(.WIDTH(WIDTH), .FRAC(FRAC)) u_lane (
            .clk_fast  (clk_fast),
            .rst       (rst),
            .load      (lane_load),
            .run       (lane_run),
            .active_in (lane_act_in[k]),
            .c_re_in   (c_re[k]),
            .c_im_in   (c_im),
            .max_iter  (max_iter_q),
            .active    (lane_active[k]),
            .fin       (lane_fin[k]),
            .count     (lane_cnt[k])
        );
    end

    assign row_end  = gx_q == GX_W'(GPR - 1);
    assign last_grp = row_end && (y_q == Y_W'(V_RES - 1));

    always_comb begin
        state_d    = state_q;
        gx_d       = gx_q;
        y_d        = y_q;
        addr_d     = addr_q;
        x_min_d    = x_min_q;
        y_max_d    = y_max_q;
        step_d     = step_q;
        max_iter_d = max_iter_q;
        wr_en_d    = wr_en_q;
        wr_data_d  = wr_data_q;
        wr_be_d    = wr_be_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d    = LOAD;
                x_min_d    = x_min;
                y_max_d    = y_max;
                step_d     = step;
                max_iter_d = max_iter;
                gx_d       = '0;
                y_d        = '0;
                addr_d     = '0;
                busy_d     = 1'b1;
            end
            LOAD: state_d = ITER;
            ITER: if (&lane_fin) begin
                state_d = WRITE;
                wr_en_d = 1'b1;
                wr_be_d = lane_active;
                for (int k = 0; k < LANES; k++)
                    wr_data_d[8*k +: 8] = lane_active[k] ? lane_cnt[k] : 8'd0;
            end
            WRITE: if (wr_ready) begin
                wr_en_d = 1'b0;
                if (last_grp) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = LOAD;
                    addr_d  = addr_q + ADDR_W'(1);
                    if (row_end) begin
                        gx_d = '0;
                        y_d  = y_q + Y_W'(1);
                    end else begin
                        gx_d = gx_q + GX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_fast or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gx_q       <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            x_min_q    <= '0;
            y_max_q    <= '0;
            step_q     <= '0;
            max_iter_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gx_q       <= gx_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            x_min_q    <= x_min_d;
            y_max_q    <= y_max_d;
            step_q     <= step_d;
            max_iter_q <= max_iter_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = addr_q;
    assign wr_data = wr_data_q;
    assign wr_be   = wr_be_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_mbt_lane_engine.sv
// Directed bench for mbt_lane_engine on a 6x2 frame (4 groups): vector table of
// viewports with hand-computed words, plus backpressure, abort and reset sequences.

module tb_mbt_lane_engine;
    localparam int LANES = 4, WIDTH = 16, FRAC = 11, H_RES = 6, V_RES = 2, ADDR_W = 17;
    localparam int NV = 9;

    logic clk_fast = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, wr_ready = 1'b0;
    logic [WIDTH-1:0] x_min = '0, y_max = '0, step = '0;
    logic [7:0] max_iter = '0;
    logic wr_en, busy, done;
    logic [ADDR_W-1:0] wr_addr;
    logic [8*LANES-1:0] wr_data;
    logic [LANES-1:0] wr_be;

    mbt_lane_engine #(.LANES(LANES), .WIDTH(WIDTH), .FRAC(FRAC), .H_RES(H_RES),
                      .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
        .clk_fast(clk_fast), .rst(rst), .start(start), .abort(abort),
        .x_min(x_min), .y_max(y_max), .step(step), .max_iter(max_iter),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_ready(wr_ready), .busy(busy), .done(done));

    always #5 clk_fast = ~clk_fast;

    typedef struct {
        logic [15:0]      x, y, st;
        logic [7:0]       mi;
        logic [3:0][31:0] d;    // expected word per address 0..3
        int               gap;  // required cycles between accepts, 0 = unchecked
    } vec_t;

    vec_t vt [NV];
    int errs = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Uniform count b on every active pixel; odd words only have lanes 0-1 in frame
    function automatic logic [3:0][31:0] mk(input logic [7:0] b);
        return {{16'h0, b, b}, {b, b, b, b}, {16'h0, b, b}, {b, b, b, b}};
    endfunction

    task automatic start_frame(input int vi);
        @(negedge clk_fast);
        x_min = vt[vi].x; y_max = vt[vi].y; step = vt[vi].st; max_iter = vt[vi].mi;
        start = 1'b1;
        @(negedge clk_fast);
        start = 1'b0;
    endtask

    task automatic wait_wr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk_fast);
            if (wr_en) ok = 1'b1;
        end
    endtask

    task automatic collect(input int vi, input int idx0);
        int idx = idx0, ndone = 0, last = -1, cyc = 0;
        bit fin = 1'b0;
        wr_ready = 1'b1;
        while (!fin && cyc < 5000) begin
            @(negedge clk_fast);
            cyc++;
            if (done) begin
                ndone++;
                @(negedge clk_fast);
                chk("busy_after_done", busy, 1'b0);
                chk("done_one_cycle", done, 1'b0);
                fin = 1'b1;
            end else if (wr_en && wr_ready) begin
                if (idx < 4) begin
                    chk($sformatf("v%0d_addr%0d", vi, idx), wr_addr, idx);
                    chk($sformatf("v%0d_data%0d", vi, idx), wr_data, vt[vi].d[idx]);
                    chk($sformatf("v%0d_be%0d", vi, idx), wr_be, (idx % 2 == 0) ? 4'hF : 4'h3);
                end
                if (vt[vi].gap != 0 && last >= 0)
                    chk($sformatf("v%0d_gap%0d", vi, idx), cyc - last, vt[vi].gap);
                last = cyc;
                idx++;
            end
        end
        chk($sformatf("v%0d_finished", vi), fin, 1'b1);
        chk($sformatf("v%0d_writes", vi), idx, 4);
        chk($sformatf("v%0d_done_pulses", vi), ndone, 1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_wr_en"}, wr_en, 1'b0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_wr_be"}, wr_be, 0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        bit ok;
        int cnt;
        // c=2.0: 0 -> 2 -> 6 escapes at count 2
        vt[0] = '{16'h1000, 16'h0000, 16'h0000, 8'd50,  mk(8'd2),   0};
        // c=0 never escapes: saturates
        vt[1] = '{16'h0000, 16'h0000, 16'h0000, 8'd50,  mk(8'd50),  0};
        // max_iter=0: all zero, 3-cycle groups
        vt[2] = '{16'h1234, 16'h0567, 16'h0011, 8'd0,   mk(8'd0),   3};
        // c=-2.0 sits on |z|^2 == 4 exactly, which is not an escape
        vt[3] = '{16'hF000, 16'h0000, 16'h0000, 8'd20,  mk(8'd20),  0};
        // c=1.0: 0,1,2,5 -> escape at count 3
        vt[4] = '{16'h0800, 16'h0000, 16'h0000, 8'd255, mk(8'd3),   0};
        // c=i: cycles -1+i, -i
        vt[5] = '{16'h0000, 16'h0800, 16'h0000, 8'd100, mk(8'd100), 0};
        // c=-1: period-2 orbit
        vt[6] = '{16'hF800, 16'h0000, 16'h0000, 8'd7,   mk(8'd7),   0};
        // max count 255
        vt[7] = '{16'h0000, 16'h0000, 16'h0000, 8'd255, mk(8'd255), 0};
        // step=1.0: row0 c=0..5, row1 c=0-i..5-i
        vt[8] = '{16'h0000, 16'h0000, 16'h0800, 8'd10,
                  {32'h00000101, 32'h0101020A, 32'h00000101, 32'h0102030A}, 0};

        repeat (3) @(negedge clk_fast);
        chk_zero_outputs("reset");
        rst = 1'b1;

        for (int vi = 0; vi < NV; vi++) begin
            start_frame(vi);
            collect(vi, 0);
        end

        // Backpressure on the first write
        wr_ready = 1'b0;
        start_frame(8);
        wait_wr(ok);
        chk("bp_first_write_seen", ok, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_fast);
            chk("bp_wr_en_held", wr_en, 1'b1);
            chk("bp_addr_held", wr_addr, 0);
            chk("bp_data_held", wr_data, 32'h0102030A);
        end
        wr_ready = 1'b1;
        @(negedge clk_fast);
        chk("bp_wr_en_dropped", wr_en, 1'b0);
        chk("bp_addr_advanced", wr_addr, 1);
        collect(8, 1);

        // Abort in the ITER of group 1
        wr_ready = 1'b1;
        start_frame(1);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk_fast);
            if (wr_en && wr_ready) ok = 1'b1;
        end
        chk("abort_first_accept_seen", ok, 1'b1);
        repeat (3) @(negedge clk_fast);
        abort = 1'b1;
        @(negedge clk_fast);
        abort = 1'b0;
        chk("abort_wr_en", wr_en, 1'b0);
        chk("abort_busy", busy, 1'b0);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_fast);
            if (done || wr_en || busy) cnt++;
        end
        chk("abort_quiet_after", cnt, 0);

        // abort and start together while busy: abort wins
        start_frame(1);
        repeat (4) @(negedge clk_fast);
        abort = 1'b1; start = 1'b1;
        @(negedge clk_fast);
        abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", busy, 1'b0);
        repeat (3) @(negedge clk_fast);
        chk("abort_start_stays_idle", busy, 1'b0);

        start_frame(1);
        collect(1, 0);

        // Asynchronous reset while a write is presented
        wr_ready = 1'b0;
        start_frame(0);
        wait_wr(ok);
        chk("rst_write_seen", ok, 1'b1);
        #2 rst = 1'b0;
        #1 chk_zero_outputs("async_rst");
        @(negedge clk_fast);
        rst = 1'b1;
        start_frame(0);
        collect(0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
